score_link: RTL and testbench

SCORE_LINK -- requirements
Module: score_link

---
 rtl/score_link_pkg.sv | 36 +++
 rtl/score_link_rx.sv | 130 +++++++++++++
 rtl/score_link.sv | 153 +++++++++++++++
 tb/tb_score_link.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_link_pkg.sv
// Shared constants and FSM state types for the score_link UART framing block.
// Optional checksum byte is enabled by defining SCORE_LINK_CHECKSUM_EN.
package score_link_pkg;

  localparam logic [7:0] HDR_BYTE   = 8'hA5;
  localparam logic [7:0] TYPE_START = 8'h01;
  localparam logic [7:0] TYPE_SCORE = 8'h02;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_PLAY = 2'b10;
  localparam logic [1:0] ST_END  = 2'b11;

  // Payload byte index; covers up to 4 payload bytes (SCORE_W <= 32)
  localparam int unsigned IDX_W = 2;

  typedef enum logic [2:0] {
    T_IDLE,
    T_HDR,
    T_TYPE,
    T_PAY
`ifdef SCORE_LINK_CHECKSUM_EN
    , T_CHK
`endif
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HUNT,
    R_TYPE,
    R_PAY
`ifdef SCORE_LINK_CHECKSUM_EN
    , R_CHK
`endif
  } rx_state_t;

endpackage

// File: rtl/score_link_rx.sv
// Receive-side frame parser: hunts for the header, collects the payload and
// publishes START / rival SCORE events. Checksum check under SCORE_LINK_CHECKSUM_EN.
module score_link_rx
  import score_link_pkg::*;
#(
  parameter int unsigned SCORE_W    = 16,
  parameter int unsigned RX_TIMEOUT = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         get_uart,
  input  logic               rx_empty,
  input  logic [1:0]         state_in,
  output logic               start_game,
  output logic [SCORE_W-1:0] score_2nd_player,
  output logic               frame_err
);

  localparam int unsigned NB   = SCORE_W / 8;
  localparam int unsigned TO_W = $clog2(RX_TIMEOUT + 1);

  rx_state_t          state, state_nxt;
  logic               pop;
  logic               timeout;
  logic               last_pay;
  logic               frame_ok;
  logic               start_nxt;
  logic               err_nxt;
  logic               score_upd;
  logic [TO_W-1:0]    idle_cnt;
  logic [IDX_W-1:0]   idx;
  logic               is_score;
  logic [SCORE_W-1:0] pay;
  logic [SCORE_W-1:0] pay_nxt;
  logic [SCORE_W-1:0] score_val;
`ifdef SCORE_LINK_CHECKSUM_EN
  logic [7:0]         chk;
`endif

  assign pop      = ~rx_empty;
  assign last_pay = (idx == IDX_W'(NB - 1));
  assign pay_nxt  = SCORE_W'({pay, get_uart});
  // Idle gap only matters once a frame has started
  assign timeout  = (state != R_HUNT) && !pop && (idle_cnt == TO_W'(RX_TIMEOUT - 1));

`ifdef SCORE_LINK_CHECKSUM_EN
  assign score_val = pay;
`else
  assign score_val = pay_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= R_HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    start_nxt = 1'b0;
    err_nxt   = 1'b0;
    score_upd = 1'b0;
    if (timeout) begin
      state_nxt = R_HUNT;
      err_nxt   = 1'b1;
    end else if (pop) begin
      case (state)
        R_HUNT: if (get_uart == HDR_BYTE) state_nxt = R_TYPE;
        R_TYPE: state_nxt = (get_uart == TYPE_START || get_uart == TYPE_SCORE) ? R_PAY : R_HUNT;
        R_PAY: begin
          if (last_pay) begin
`ifdef SCORE_LINK_CHECKSUM_EN
            state_nxt = R_CHK;
`else
            state_nxt = R_HUNT;
            frame_ok  = 1'b1;
`endif
          end
        end
`ifdef SCORE_LINK_CHECKSUM_EN
        R_CHK: begin
          state_nxt = R_HUNT;
          if (get_uart == chk) frame_ok = 1'b1;
          else                 err_nxt  = 1'b1;
        end
`endif
        default: state_nxt = R_HUNT;
      endcase
    end
    if (frame_ok) begin
      if (!is_score) start_nxt = 1'b1;
      else if (state_in == ST_PLAY || state_in == ST_END) score_upd = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt         <= '0;
      idx              <= '0;
      is_score         <= 1'b0;
      pay              <= '0;
      start_game       <= 1'b0;
      frame_err        <= 1'b0;
      score_2nd_player <= '0;
`ifdef SCORE_LINK_CHECKSUM_EN
      chk              <= '0;
`endif
    end else begin
      start_game <= start_nxt;
      frame_err  <= err_nxt;
      if (score_upd) score_2nd_player <= score_val;
      idle_cnt <= (pop || state == R_HUNT) ? '0 : idle_cnt + TO_W'(1);
      if (pop && state == R_TYPE) begin
        is_score <= (get_uart == TYPE_SCORE);
        idx      <= '0;
`ifdef SCORE_LINK_CHECKSUM_EN
        chk      <= get_uart;
`endif
      end
      if (pop && state == R_PAY) begin
        pay <= pay_nxt;
        idx <= idx + IDX_W'(1);
`ifdef SCORE_LINK_CHECKSUM_EN
        chk <= chk ^ get_uart;
`endif
      end
    end
  end

endmodule

// File: rtl/score_link.sv
// Score exchange link over a byte FIFO UART: periodic/on-change TX framing plus
// the RX parser. Checksum byte is enabled by defining SCORE_LINK_CHECKSUM_EN.
module score_link
  import score_link_pkg::*;
#(
  parameter int unsigned SCORE_W    = 16,
  parameter int unsigned TX_PERIOD  = 1_000_000,
  parameter int unsigned RX_TIMEOUT = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         get_uart,
  input  logic               rx_empty,
  output logic               rd_uart,
  output logic [7:0]         send_uart,
  input  logic               tx_full,
  output logic               wr_uart,
  input  logic [1:0]         state_in,
  input  logic [SCORE_W-1:0] my_score,
  output logic               start_game,
  output logic [SCORE_W-1:0] score_2nd_player,
  output logic               frame_err
);

  localparam int unsigned NB    = SCORE_W / 8;
  localparam int unsigned CNT_W = (TX_PERIOD > 1) ? $clog2(TX_PERIOD) : 1;

  tx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   per_cnt;
  logic               wrap;
  logic               score_chg;
  logic               req;
  logic               launch;
  logic               send;
  logic [7:0]         req_type;
  logic [7:0]         launch_type;
  logic [SCORE_W-1:0] launch_pay;
  logic               pend;
  logic [7:0]         pend_type;
  logic [SCORE_W-1:0] prev_score;
  logic [7:0]         tx_type;
  logic [SCORE_W-1:0] tx_pay;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         tx_byte;
`ifdef SCORE_LINK_CHECKSUM_EN
  logic [7:0]         tx_chk;
`endif

  assign wrap        = (per_cnt == CNT_W'(TX_PERIOD - 1));
  assign score_chg   = (state_in == ST_PLAY) && (my_score != prev_score);
  assign req         = (wrap && (state_in == ST_WAIT || state_in == ST_PLAY)) || score_chg;
  assign req_type    = (state_in == ST_WAIT) ? TYPE_START : TYPE_SCORE;
  assign launch      = (state == T_IDLE) && (req || pend);
  assign launch_type = req ? req_type : pend_type;
  assign launch_pay  = (launch_type == TYPE_START) ? '0 : my_score;
  assign send        = (state != T_IDLE) && !tx_full;

  assign rd_uart   = ~rx_empty & ~rst;
  assign wr_uart   = send & ~rst;
  assign send_uart = rst ? 8'h00 : tx_byte;

  always_ff @(posedge clk) begin
    if (rst) state <= T_IDLE;
    else     state <= state_nxt;
  end

  // Byte selection and advance; every state holds while the TX FIFO is full
  always_comb begin
    state_nxt = state;
    tx_byte   = 8'h00;
    case (state)
      T_IDLE: if (launch) state_nxt = T_HDR;
      T_HDR: begin
        tx_byte = HDR_BYTE;
        if (!tx_full) state_nxt = T_TYPE;
      end
      T_TYPE: begin
        tx_byte = tx_type;
        if (!tx_full) state_nxt = T_PAY;
      end
      T_PAY: begin
        tx_byte = tx_pay[SCORE_W-1 -: 8];
        if (!tx_full && idx == IDX_W'(NB - 1)) begin
`ifdef SCORE_LINK_CHECKSUM_EN
          state_nxt = T_CHK;
`else
          state_nxt = T_IDLE;
`endif
        end
      end
`ifdef SCORE_LINK_CHECKSUM_EN
      T_CHK: begin
        tx_byte = tx_chk;
        if (!tx_full) state_nxt = T_IDLE;
      end
`endif
      default: state_nxt = T_IDLE;
    endcase
  end

  // prev_score snapshots the live score in reset so release does not look like a change
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt    <= '0;
      pend       <= 1'b0;
      pend_type  <= TYPE_SCORE;
      prev_score <= my_score;
      tx_type    <= '0;
      tx_pay     <= '0;
      idx        <= '0;
`ifdef SCORE_LINK_CHECKSUM_EN
      tx_chk     <= '0;
`endif
    end else begin
      prev_score <= my_score;
      per_cnt    <= (wrap || score_chg) ? '0 : per_cnt + CNT_W'(1);
      if (launch) begin
        tx_type <= launch_type;
        tx_pay  <= launch_pay;
        idx     <= '0;
        pend    <= 1'b0;
`ifdef SCORE_LINK_CHECKSUM_EN
        tx_chk  <= launch_type;
`endif
      end else if (req) begin
        pend      <= 1'b1;
        pend_type <= req_type;
      end
      if (send && state == T_PAY) begin
        tx_pay <= tx_pay << 8;
        idx    <= idx + IDX_W'(1);
`ifdef SCORE_LINK_CHECKSUM_EN
        tx_chk <= tx_chk ^ tx_pay[SCORE_W-1 -: 8];
`endif
      end
    end
  end

  score_link_rx #(
    .SCORE_W   (SCORE_W),
    .RX_TIMEOUT(RX_TIMEOUT)
  ) u_rx (
    .clk             (clk),
    .rst             (rst),
    .get_uart        (get_uart),
    .rx_empty        (rx_empty),
    .state_in        (state_in),
    .start_game      (start_game),
    .score_2nd_player(score_2nd_player),
    .frame_err       (frame_err)
  );

endmodule

// File: tb/tb_score_link.sv
// Scoreboard bench for score_link: frame-level RX expectations and a TX frame
// model feed queues that negedge monitors drain. Honours SCORE_LINK_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_score_link;

  localparam int unsigned SCORE_W    = 16;
  localparam int unsigned TX_PERIOD  = 100;
  localparam int unsigned RX_TIMEOUT = 50;
  localparam int          NB         = SCORE_W / 8;
`ifdef SCORE_LINK_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int EV_START = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_SCORE = 3;

  typedef struct {
    int          kind;
    logic [15:0] val;
    int          stamp;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  get_uart;
  logic        rx_empty;
  logic        rd_uart;
  logic [7:0]  send_uart;
  logic        tx_full;
  logic        wr_uart;
  logic [1:0]  state_in;
  logic [15:0] my_score;
  logic        start_game;
  logic [15:0] score_2nd_player;
  logic        frame_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          mon_en  = 1'b0;
  bit          tx_rand_en = 1'b0;
  logic [15:0] exp_score = '0;
  logic [15:0] seen_score = '0;
  ev_t         rx_exp[$];
  logic [7:0]  tx_exp[$];

  int          m_cnt, m_left;
  bit          m_pend, m_pend_start;
  logic [15:0] m_prev;

  score_link #(
    .SCORE_W(SCORE_W), .TX_PERIOD(TX_PERIOD), .RX_TIMEOUT(RX_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .get_uart(get_uart), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .send_uart(send_uart), .tx_full(tx_full), .wr_uart(wr_uart), .state_in(state_in),
    .my_score(my_score), .start_game(start_game), .score_2nd_player(score_2nd_player),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_rand_en) tx_full = ($urandom_range(0, 3) == 0);
  endtask

  // Whole-frame byte list for one transmitted frame
  task automatic push_frame(input bit is_start, input logic [15:0] score);
    logic [7:0]  typ, ck;
    logic [15:0] p;
    typ = is_start ? 8'h01 : 8'h02;
    p   = is_start ? 16'h0000 : score;
    ck  = typ;
    tx_exp.push_back(8'hA5);
    tx_exp.push_back(typ);
    for (int i = NB - 1; i >= 0; i--) begin
      tx_exp.push_back(p[i*8 +: 8]);
      ck ^= p[i*8 +: 8];
    end
    if (CHK_EN) tx_exp.push_back(ck);
  endtask

  // TX reference: period timer, change trigger and a single merged pending request
  always @(posedge clk) begin : tx_model
    bit wrap, chg, req, req_start;
    if (rst) begin
      m_cnt  = 0;
      m_left = 0;
      m_pend = 1'b0;
      m_prev = my_score;
      tx_exp.delete();
    end else begin
      wrap      = (m_cnt == int'(TX_PERIOD) - 1);
      chg       = (state_in == 2'b10) && (my_score != m_prev);
      req       = (wrap && (state_in == 2'b01 || state_in == 2'b10)) || chg;
      req_start = (state_in == 2'b01);
      m_cnt     = (wrap || chg) ? 0 : m_cnt + 1;
      m_prev    = my_score;
      if (m_left == 0) begin
        if (req || m_pend) begin
          push_frame(req ? req_start : m_pend_start, my_score);
          m_left = NB + 2 + int'(CHK_EN);
          m_pend = 1'b0;
        end
      end else begin
        if (req) begin
          m_pend       = 1'b1;
          m_pend_start = req_start;
        end
        if (!tx_full) m_left--;
      end
    end
  end

  task automatic rx_pop(input int kind, input logic [15:0] val);
    ev_t e;
    if (rx_exp.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_unexpected: got event kind %0d value 0x%0h, want none (cycle %0d)", kind, val, cyc);
    end else begin
      e = rx_exp.pop_front();
      check("rx_kind", 32'(kind), 32'(e.kind));
      if (kind == EV_SCORE) check("rx_score", 32'(val), 32'(e.val));
      if (e.stamp != 0) check("rx_latency", 32'(cyc), 32'(e.stamp));
    end
  endtask

  always @(negedge clk) begin : monitor
    if (mon_en && !rst) begin
      check("rd_uart", 32'(rd_uart), 32'(!rx_empty));
      if (tx_full) check("wr_while_full", 32'(wr_uart), 32'h0);
      if (wr_uart) begin
        if (tx_exp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte 0x%0h, want none (cycle %0d)", send_uart, cyc);
        end else begin
          check("tx_byte", 32'(send_uart), 32'(tx_exp.pop_front()));
        end
      end
      if (start_game) rx_pop(EV_START, 16'h0);
      if (frame_err)  rx_pop(EV_ERR, 16'h0);
      if (score_2nd_player !== seen_score) begin
        rx_pop(EV_SCORE, score_2nd_player);
        seen_score = score_2nd_player;
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b, input int gap_max);
    rx_empty = 1'b0;
    get_uart = b;
    tick();
    rx_empty = 1'b1;
    repeat ($urandom_range(0, gap_max)) tick();
  endtask

  // Sends one frame and predicts its outcome from the frame rules
  task automatic send_frame(input logic [7:0] typ, input logic [15:0] pay,
                            input bit corrupt, input int gap_max);
    logic [7:0] b[$];
    logic [7:0] ck;
    ev_t        e;
    ck = typ;
    b.push_back(8'hA5);
    b.push_back(typ);
    for (int i = NB - 1; i >= 0; i--) begin
      b.push_back(pay[i*8 +: 8]);
      ck ^= pay[i*8 +: 8];
    end
    if (CHK_EN) b.push_back(corrupt ? (ck ^ 8'h01) : ck);
    e.kind = 0;
    e.val  = pay;
    if (CHK_EN && corrupt) e.kind = EV_ERR;
    else if (typ == 8'h01) e.kind = EV_START;
    else if (typ == 8'h02 && state_in[1] && pay != exp_score) begin
      e.kind    = EV_SCORE;
      exp_score = pay;
    end
    for (int i = 0; i < b.size(); i++) begin
      if (i == b.size() - 1 && e.kind != 0) begin
        e.stamp = cyc + 1;
        rx_exp.push_back(e);
      end
      rx_byte(b[i], (i == b.size() - 1) ? 0 : gap_max);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_uart"}, 32'(rd_uart), 32'h0);
    check({tag, "_wr_uart"}, 32'(wr_uart), 32'h0);
    check({tag, "_send_uart"}, 32'(send_uart), 32'h0);
    check({tag, "_start_game"}, 32'(start_game), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_score"}, 32'(score_2nd_player), 32'h0);
  endtask

  initial begin
    ev_t e;
    int  waited;
    rst      = 1'b1;
    rx_empty = 1'b0;
    get_uart = 8'h5A;
    tx_full  = 1'b0;
    state_in = 2'b00;
    my_score = 16'h0000;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst      = 1'b0;
    rx_empty = 1'b1;
    mon_en   = 1'b1;
    tick();

    // Valid rival score in PLAY
    state_in = 2'b10;
    send_frame(8'h02, 16'h1234, 1'b0, 0);
    repeat (3) tick();
    check("score_1234", 32'(score_2nd_player), 32'h1234);
    // Bad checksum
    send_frame(8'h02, 16'h1234, 1'b1, 0);
    repeat (3) tick();
    // START in IDLE
    state_in = 2'b00;
    send_frame(8'h01, 16'h0000, 1'b0, 1);
    repeat (3) tick();

    // Stalled frame times out, next frame still accepted
    state_in = 2'b10;
    rx_byte(8'hA5, 0);
    rx_byte(8'h02, 0);
    e.kind = EV_ERR; e.val = '0; e.stamp = 0;
    rx_exp.push_back(e);
    rx_byte(8'h12, 0);
    repeat (60) tick();
    send_frame(8'h02, 16'h5678, 1'b0, 2);
    repeat (3) tick();
    check("score_5678", 32'(score_2nd_player), 32'h5678);

    // Reset in the middle of a received frame
    rx_byte(8'hA5, 0);
    rx_byte(8'h02, 0);
    mon_en   = 1'b0;
    rst      = 1'b1;
    rx_empty = 1'b0;
    get_uart = 8'h33;
    tick();
    check_reset_outputs("midrst");
    rst        = 1'b0;
    rx_empty   = 1'b1;
    exp_score  = '0;
    seen_score = '0;
    rx_exp.delete();
    mon_en     = 1'b1;
    tick();
    send_frame(8'h02, 16'h00AB, 1'b0, 1);
    repeat (3) tick();
    check("score_after_rst", 32'(score_2nd_player), 32'h00AB);

    // Local score 7 in PLAY with a mid-frame TX stall
    my_score = 16'h0007;
    waited   = 0;
    while (!wr_uart && waited < 300) begin
      tick();
      waited++;
    end
    check("tx_started", 32'(wr_uart), 32'h1);
    tick();
    tx_full = 1'b1;
    repeat (10) tick();
    tx_full = 1'b0;
    repeat (250) tick();

    // Randomized traffic on both directions
    tx_rand_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      logic [7:0] g;
      if ($urandom_range(0, 2) == 0) state_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) my_score = 16'($urandom);
      case ($urandom_range(0, 4))
        0, 1: send_frame(8'h02, 16'($urandom), 1'b0, 2);
        2:    send_frame(8'h01, 16'h0000, 1'b0, 2);
        3:    send_frame(8'h02, 16'($urandom), 1'b1, 2);
        default: begin
          g = 8'($urandom_range(3, 255));
          if (g == 8'hA5) g = 8'h5A;
          if ($urandom_range(0, 1) == 0) rx_byte(g, 1);
          else begin
            rx_byte(8'hA5, 1);
            rx_byte(g, 1);
          end
        end
      endcase
      repeat ($urandom_range(0, 20)) tick();
    end

    // Drain outstanding TX work
    tx_rand_en = 1'b0;
    tx_full    = 1'b0;
    state_in   = 2'b00;
    waited     = 0;
    while ((m_left != 0 || m_pend || tx_exp.size() != 0) && waited < 200) begin
      tick();
      waited++;
    end
    repeat (5) tick();
    check("tx_queue_drained", 32'(tx_exp.size()), 32'h0);
    check("rx_queue_drained", 32'(rx_exp.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
